// File: rtl/vdp_port_ctrl.sv
// CPU-side port controller for the MSX video block: decodes the data/control
// ports into register writes, VRAM accesses with read-ahead, and status flags.
module vdp_port_ctrl #(
    parameter int VRAM_AW = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_port,
    input  logic               cpu_wr,
    input  logic               cpu_rd,
    input  logic [7:0]         cpu_din,
    output logic [7:0]         cpu_dout,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_wr,
    output logic               vram_rd,
    output logic [7:0]         vram_din,
    input  logic [7:0]         vram_dout,
    input  logic               frame_pulse,
    input  logic               collision_in,
    output logic               n_int,
    output logic [1:0]         mode,
    output logic [13:0]        name_table_addr,
    output logic [13:0]        color_table_addr,
    output logic [13:0]        font_addr,
    output logic [13:0]        sprite_attr_addr,
    output logic [13:0]        sprite_pattern_table_addr,
    output logic               video_on,
    output logic               sprite_large,
    output logic               sprite_enlarged,
    output logic               vert_retrace_int,
    output logic [3:0]         text_color,
    output logic [3:0]         back_color
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         regs [0:7];
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_AW-1:0] wr_addr;
    logic [7:0]         latch;
    logic [7:0]         buffer;
    logic [7:0]         wr_data;
    logic               first_byte;
    logic               flag_f;
    logic               flag_c;

    // A simultaneous write and read is illegal; the write wins.
    logic rd_ev;
    logic data_wr;
    logic ctrl_wr;
    logic data_rd;
    logic stat_rd;
    logic addr_setup;
    logic start_ra;

    assign rd_ev      = cpu_rd & ~cpu_wr;
    assign data_wr    = cpu_wr & ~cpu_port;
    assign ctrl_wr    = cpu_wr & cpu_port;
    assign data_rd    = rd_ev & ~cpu_port;
    assign stat_rd    = rd_ev & cpu_port;
    assign addr_setup = ctrl_wr & first_byte & ~cpu_din[7];
    assign start_ra   = (addr_setup & ~cpu_din[6]) | data_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A data write always preempts a pending read-ahead.
    always_comb begin
        state_next = state;
        vram_rd    = 1'b0;
        vram_wr    = 1'b0;
        vram_addr  = addr;
        vram_din   = wr_data;
        case (state)
            IDLE: state_next = IDLE;
            RD: begin
                vram_rd    = 1'b1;
                state_next = CAP;
            end
            CAP: state_next = IDLE;
            WR: begin
                vram_wr    = 1'b1;
                vram_addr  = wr_addr;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (data_wr) begin
            state_next = WR;
        end else if (start_ra) begin
            state_next = RD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
            addr       <= '0;
            wr_addr    <= '0;
            latch      <= 8'h00;
            buffer     <= 8'h00;
            wr_data    <= 8'h00;
            first_byte <= 1'b0;
            flag_f     <= 1'b0;
            flag_c     <= 1'b0;
            cpu_dout   <= 8'h00;
        end else begin
            if (stat_rd) begin
                flag_f <= frame_pulse;
                flag_c <= collision_in;
            end else begin
                flag_f <= flag_f | frame_pulse;
                flag_c <= flag_c | collision_in;
            end

            if (data_wr) begin
                first_byte <= 1'b0;
                wr_addr    <= addr;
                wr_data    <= cpu_din;
                buffer     <= cpu_din;
                addr       <= addr + VRAM_AW'(1);
            end else if (ctrl_wr) begin
                if (!first_byte) begin
                    latch      <= cpu_din;
                    first_byte <= 1'b1;
                end else begin
                    first_byte <= 1'b0;
                    if (cpu_din[7]) begin
                        regs[cpu_din[2:0]] <= latch;
                    end else begin
                        addr <= VRAM_AW'({cpu_din[5:0], latch});
                    end
                end
            end else if (data_rd) begin
                first_byte <= 1'b0;
                cpu_dout   <= buffer;
                addr       <= addr + VRAM_AW'(1);
            end else if (stat_rd) begin
                first_byte <= 1'b0;
                cpu_dout   <= {flag_f, 1'b0, flag_c, 5'b0};
            end

            if (state == CAP && !data_wr && !start_ra) begin
                buffer <= vram_dout;
            end
        end
    end

    logic m1;
    logic m2;
    logic m3;

    assign m1 = regs[1][4];
    assign m2 = regs[1][3];
    assign m3 = regs[0][1];

    always_comb begin
        if (m1) begin
            mode = 2'd0;
        end else if (m2) begin
            mode = 2'd3;
        end else if (m3) begin
            mode = 2'd2;
        end else begin
            mode = 2'd1;
        end
    end

    // Graphics 2 uses only the top bit of R3/R4 as an 8 KB half select.
    assign name_table_addr  = {regs[2][3:0], 10'b0};
    assign color_table_addr = (mode == 2'd2) ? {regs[3][7], 13'b0} : {regs[3], 6'b0};
    assign font_addr        = (mode == 2'd2) ? {regs[4][2], 13'b0} : {regs[4][2:0], 11'b0};
    assign sprite_attr_addr          = {regs[5][6:0], 7'b0};
    assign sprite_pattern_table_addr = {regs[6][2:0], 11'b0};

    assign video_on         = regs[1][6];
    assign vert_retrace_int = regs[1][5];
    assign sprite_large     = regs[1][1];
    assign sprite_enlarged  = regs[1][0];
    assign text_color       = regs[7][7:4];
    assign back_color       = regs[7][3:0];

    assign n_int = ~(flag_f & regs[1][5]);

    logic unused_reg_bits;
    assign unused_reg_bits = ^{regs[0][7:2], regs[0][0], regs[1][7], regs[1][2],
                               regs[2][7:4], regs[4][7:3], regs[5][7], regs[6][7:3]};

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Directed bench for vdp_port_ctrl: register decode, VRAM write/read-ahead
// sequencing against a VRAM model, status flags and reset behaviour.
module tb_vdp_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_port;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic [13:0] vram_addr;
    logic        vram_wr;
    logic        vram_rd;
    logic [7:0]  vram_din;
    logic [7:0]  vram_dout;
    logic        frame_pulse;
    logic        collision_in;
    logic        n_int;
    logic [1:0]  mode;
    logic [13:0] name_table_addr;
    logic [13:0] color_table_addr;
    logic [13:0] font_addr;
    logic [13:0] sprite_attr_addr;
    logic [13:0] sprite_pattern_table_addr;
    logic        video_on;
    logic        sprite_large;
    logic        sprite_enlarged;
    logic        vert_retrace_int;
    logic [3:0]  text_color;
    logic [3:0]  back_color;

    int checks = 0;
    int errors = 0;

    logic [21:0] exp_q[$];
    logic [13:0] rd_q[$];
    logic [13:0] model_addr = 14'h0;
    logic [7:0]  rdata;
    logic [7:0]  vram_mem [0:16383];

    vdp_port_ctrl #(.VRAM_AW(14)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .cpu_port                  (cpu_port),
        .cpu_wr                    (cpu_wr),
        .cpu_rd                    (cpu_rd),
        .cpu_din                   (cpu_din),
        .cpu_dout                  (cpu_dout),
        .vram_addr                 (vram_addr),
        .vram_wr                   (vram_wr),
        .vram_rd                   (vram_rd),
        .vram_din                  (vram_din),
        .vram_dout                 (vram_dout),
        .frame_pulse               (frame_pulse),
        .collision_in              (collision_in),
        .n_int                     (n_int),
        .mode                      (mode),
        .name_table_addr           (name_table_addr),
        .color_table_addr          (color_table_addr),
        .font_addr                 (font_addr),
        .sprite_attr_addr          (sprite_attr_addr),
        .sprite_pattern_table_addr (sprite_pattern_table_addr),
        .video_on                  (video_on),
        .sprite_large              (sprite_large),
        .sprite_enlarged           (sprite_enlarged),
        .vert_retrace_int          (vert_retrace_int),
        .text_color                (text_color),
        .back_color                (back_color)
    );

    // Clock and VRAM model (1-cycle read latency)
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vram_wr) vram_mem[vram_addr] <= vram_din;
        if (vram_rd) vram_dout <= vram_mem[vram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: VRAM strobes are popped against expectations queued by the drivers
    always @(negedge clk) begin
        if (vram_wr === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_vram_wr", 32'(vram_wr), 32'h0);
            else check("vram_wr_addr_data", 32'({vram_addr, vram_din}), 32'(exp_q.pop_front()));
        end
        if (vram_rd === 1'b1) begin
            if (rd_q.size() == 0) check("unexpected_vram_rd", 32'(vram_rd), 32'h0);
            else check("vram_rd_addr", 32'(vram_addr), 32'(rd_q.pop_front()));
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic port, input logic [7:0] d);
        @(negedge clk);
        cpu_port = port; cpu_din = d; cpu_wr = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b0;
        idle(4);
    endtask

    task automatic cpu_read(input logic port, output logic [7:0] d);
        @(negedge clk);
        cpu_port = port; cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        idle(4);
        d = cpu_dout;
    endtask

    task automatic reg_write(input logic [2:0] idx, input logic [7:0] val);
        cpu_write(1'b1, val);
        cpu_write(1'b1, {5'b10000, idx});
    endtask

    task automatic set_addr(input logic [13:0] a, input logic for_read);
        cpu_write(1'b1, a[7:0]);
        model_addr = a;
        if (for_read) rd_q.push_back(a);
        cpu_write(1'b1, {1'b0, ~for_read, a[13:8]});
    endtask

    task automatic data_write(input logic [7:0] d);
        exp_q.push_back({model_addr, d});
        model_addr = model_addr + 14'h1;
        cpu_write(1'b0, d);
    endtask

    task automatic data_read(output logic [7:0] d);
        model_addr = model_addr + 14'h1;
        rd_q.push_back(model_addr);
        cpu_read(1'b0, d);
    endtask

    task automatic pulse_frame();
        @(negedge clk); frame_pulse = 1'b1;
        @(negedge clk); frame_pulse = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_addr = 14'h0;
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_port = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_din = 8'h00;
        frame_pulse = 1'b0; collision_in = 1'b0;
        idle(3);
        check("reset_cpu_dout", 32'(cpu_dout), 32'h00);
        check("reset_n_int", 32'(n_int), 32'h1);
        check("reset_vram_wr", 32'(vram_wr), 32'h0);
        check("reset_vram_rd", 32'(vram_rd), 32'h0);
        check("reset_mode", 32'(mode), 32'h1);
        reset = 1'b0;
        idle(2);

        // Register writes
        reg_write(3'd7, 8'hF4);
        check("r7_back_color", 32'(back_color), 32'h4);
        check("r7_text_color", 32'(text_color), 32'hF);
        check("no_vram_after_reg", 32'(exp_q.size()), 32'h0);
        reg_write(3'd2, 8'h0F);
        check("name_table_0f", 32'(name_table_addr), 32'h3C00);
        reg_write(3'd2, 8'h00);
        check("name_table_00", 32'(name_table_addr), 32'h0000);

        // Mode and table decode
        reg_write(3'd0, 8'h02);
        reg_write(3'd1, 8'h40);
        check("mode_g2", 32'(mode), 32'h2);
        check("video_on", 32'(video_on), 32'h1);
        reg_write(3'd4, 8'h04);
        check("font_g2_hi", 32'(font_addr), 32'h2000);
        reg_write(3'd4, 8'h03);
        check("font_g2_lo", 32'(font_addr), 32'h0000);
        reg_write(3'd3, 8'hFF);
        check("color_g2", 32'(color_table_addr), 32'h2000);
        reg_write(3'd0, 8'h00);
        check("mode_g1", 32'(mode), 32'h1);
        check("font_g1", 32'(font_addr), 32'h1800);
        check("color_g1", 32'(color_table_addr), 32'h3FC0);
        reg_write(3'd1, 8'h18);
        check("mode_text_priority", 32'(mode), 32'h0);
        reg_write(3'd1, 8'h08);
        check("mode_multicolour", 32'(mode), 32'h3);
        reg_write(3'd1, 8'h03);
        check("sprite_flags", 32'({sprite_large, sprite_enlarged, video_on}), 32'h6);
        reg_write(3'd5, 8'hFF);
        check("sprite_attr", 32'(sprite_attr_addr), 32'h3F80);
        reg_write(3'd6, 8'h07);
        check("sprite_pattern", 32'(sprite_pattern_table_addr), 32'h3800);

        // Write auto-increment across the wrap point
        set_addr(14'h3FFF, 1'b0);
        data_write(8'hAA);
        data_write(8'h55);

        // Read-ahead
        set_addr(14'h1234, 1'b0);
        data_write(8'h5A);
        data_write(8'hC3);
        set_addr(14'h1234, 1'b1);
        data_read(rdata);
        check("read_ahead_first", 32'(rdata), 32'h5A);
        data_read(rdata);
        check("read_ahead_second", 32'(rdata), 32'hC3);

        // Data write landing while the read-ahead is in RD
        cpu_write(1'b1, 8'h00);
        rd_q.push_back(14'h0100);
        exp_q.push_back({14'h0100, 8'h3C});
        @(negedge clk); cpu_port = 1'b1; cpu_din = 8'h01; cpu_wr = 1'b1;
        @(negedge clk); cpu_port = 1'b0; cpu_din = 8'h3C;
        @(negedge clk); cpu_wr = 1'b0;
        idle(4);
        model_addr = 14'h0101;
        data_read(rdata);
        check("abort_in_rd", 32'(rdata), 32'h3C);

        // Data write landing while the read-ahead is in CAP
        cpu_write(1'b1, 8'h00);
        rd_q.push_back(14'h0200);
        exp_q.push_back({14'h0200, 8'hE1});
        @(negedge clk); cpu_port = 1'b1; cpu_din = 8'h02; cpu_wr = 1'b1;
        @(negedge clk); cpu_wr = 1'b0;
        @(negedge clk); cpu_port = 1'b0; cpu_din = 8'hE1; cpu_wr = 1'b1;
        @(negedge clk); cpu_wr = 1'b0;
        idle(4);
        model_addr = 14'h0201;
        data_read(rdata);
        check("abort_in_cap", 32'(rdata), 32'hE1);

        // Status and interrupt
        reg_write(3'd1, 8'h20);
        check("vert_retrace_int", 32'(vert_retrace_int), 32'h1);
        pulse_frame();
        check("n_int_asserted", 32'(n_int), 32'h0);
        cpu_read(1'b1, rdata);
        check("status_frame", 32'(rdata), 32'h80);
        check("n_int_cleared", 32'(n_int), 32'h1);
        cpu_read(1'b1, rdata);
        check("status_empty", 32'(rdata), 32'h00);
        pulse_frame();
        reg_write(3'd1, 8'h00);
        check("n_int_masked", 32'(n_int), 32'h1);
        cpu_read(1'b1, rdata);
        check("status_f_kept", 32'(rdata), 32'h80);
        @(negedge clk); collision_in = 1'b1;
        @(negedge clk); collision_in = 1'b0;
        idle(3);
        pulse_frame();
        cpu_read(1'b1, rdata);
        check("status_both", 32'(rdata), 32'hA0);
        @(negedge clk); cpu_port = 1'b1; cpu_rd = 1'b1; frame_pulse = 1'b1;
        @(negedge clk); cpu_rd = 1'b0; frame_pulse = 1'b0;
        idle(4);
        check("status_race_read", 32'(cpu_dout), 32'h00);
        cpu_read(1'b1, rdata);
        check("status_race_kept", 32'(rdata), 32'h80);

        // Reset in the middle of a VRAM write
        @(negedge clk); cpu_port = 1'b0; cpu_din = 8'h99; cpu_wr = 1'b1;
        @(posedge clk); #1 reset = 1'b1; cpu_wr = 1'b0;
        #1 check("reset_aborts_wr", 32'(vram_wr), 32'h0);
        @(negedge clk);
        check("reset_dout", 32'(cpu_dout), 32'h00);
        check("reset_mode_again", 32'(mode), 32'h1);
        check("reset_text_color", 32'(text_color), 32'h0);
        @(negedge clk); reset = 1'b0;
        model_addr = 14'h0;
        idle(2);
        data_read(rdata);
        check("reset_buffer", 32'(rdata), 32'h00);
        data_write(8'h77);

        // Reset clears a half-written control pair
        cpu_write(1'b1, 8'h12);
        pulse_reset();
        reg_write(3'd7, 8'h00);
        check("reset_first_byte_a", 32'({text_color, back_color}), 32'h00);
        cpu_write(1'b1, 8'h34);
        pulse_reset();
        reg_write(3'd7, 8'h5A);
        check("reset_first_byte_b", 32'({text_color, back_color}), 32'h5A);

        idle(4);
        check("wr_queue_drained", 32'(exp_q.size()), 32'h0);
        check("rd_queue_drained", 32'(rd_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
